// File: rtl/xnor_cmp_scheduler_if.sv
// rtl/xnor_cmp_scheduler_if.sv - request/operand/result bundle shared by the comparator scheduler and its clients
interface xnor_cmp_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int MIW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] a_in;
  logic [N_REQ*WIDTH-1:0] b_in;
  logic [N_REQ-1:0]       gnt;
  logic                   busy;
  logic                   done;
  logic                   eq;
  logic [IDW-1:0]         done_id;
  logic [MIW-1:0]         mis_idx;

  modport master (
    output req, a_in, b_in,
    input  gnt, busy, done, eq, done_id, mis_idx
  );

  modport slave (
    input  req, a_in, b_in,
    output gnt, busy, done, eq, done_id, mis_idx
  );
endinterface

// File: rtl/xnor_cmp_scheduler.sv
// rtl/xnor_cmp_scheduler.sv - round-robin shared bit-serial XNOR equality comparator
module xnor_cmp_scheduler #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  xnor_cmp_scheduler_if.slave  bus
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int MIW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // One extra bit so the counter can represent WIDTH without wrapping.
  localparam int CW  = MIW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic [MIW-1:0]   mis_q, mis_d;

  logic             found;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   cand_id;
  int               cand;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [N_REQ-1:0] gnt_c;
  logic             bit_eq;

  // Round-robin search starting just after the last winner, wrapping around.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    cand    = 0;
    cand_id = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand    = (int'(last_q) + off) % N_REQ;
      cand_id = IDW'(cand);
      if (!found && bus.req[cand_id]) begin
        found  = 1'b1;
        winner = cand_id;
      end
    end
  end

  // Operand mux for the current winner, built from constant slices.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == IDW'(i)) begin
        sel_a = bus.a_in[i*WIDTH +: WIDTH];
        sel_b = bus.b_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state logic: grant/capture in IDLE, one bit per cycle in RUN, single-cycle DONE.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mis_d   = mis_q;
    gnt_c   = '0;
    bit_eq  = a_q[0] ~^ b_q[0];
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_c   = N_REQ'(1) << winner;
          last_d  = winner;
          a_d     = sel_a;
          b_d     = sel_b;
          cnt_d   = '0;
          acc_d   = 1'b1;
          mis_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = acc_q & bit_eq;
        // acc_q still high means no earlier mismatch, so this is the first one.
        if (acc_q && !bit_eq) begin
          mis_d = cnt_q[MIW-1:0];
        end
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset leaves requester 0 with first priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= IDW'(N_REQ - 1);
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      mis_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mis_q   <= mis_d;
    end
  end

  // Result outputs are gated to zero outside the DONE cycle; grant is masked during reset.
  assign bus.gnt     = rst ? '0 : gnt_c;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_DONE);
  assign bus.eq      = bus.done & acc_q;
  assign bus.done_id = bus.done ? last_q : '0;
  assign bus.mis_idx = bus.done ? mis_q : '0;
endmodule

// File: tb/tb_xnor_cmp_scheduler.sv
// tb/tb_xnor_cmp_scheduler.sv - scoreboard bench for the round-robin XNOR comparator scheduler
module tb_xnor_cmp_scheduler;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xnor_cmp_scheduler_if #(.N_REQ(N), .WIDTH(W)) bus ();

  xnor_cmp_scheduler #(.N_REQ(N), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [N-1:0] gnt;
    int           gap;
  } gnt_exp_t;

  typedef struct {
    logic       eq;
    logic [1:0] id;
    logic [2:0] mis;
  } res_exp_t;

  gnt_exp_t gq[$];
  res_exp_t rq[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: compares every grant and result against the scoreboard queues.
  int       last_gnt_cyc = -1;
  int       job_gnt_cyc  = -1;
  logic     in_job       = 1'b0;
  gnt_exp_t ge;
  res_exp_t re;

  always @(negedge clk) begin
    if (rst) begin
      check("reset_outs", {bus.gnt, bus.busy, bus.done, bus.eq, bus.done_id, bus.mis_idx}, 32'd0);
      in_job      = 1'b0;
      job_gnt_cyc = -1;
    end else begin
      check("busy", {31'd0, bus.busy}, {31'd0, in_job});
      if (bus.gnt != '0) begin
        if (gq.size() == 0) begin
          flag("unexpected_grant");
        end else begin
          ge = gq.pop_front();
          check("gnt", {28'd0, bus.gnt}, {28'd0, ge.gnt});
          if (ge.gap > 0) check("gnt_gap", cyc - last_gnt_cyc, ge.gap);
        end
        last_gnt_cyc = cyc;
        job_gnt_cyc  = cyc;
      end
      if (bus.done) begin
        if (rq.size() == 0) begin
          flag("unexpected_done");
        end else begin
          re = rq.pop_front();
          check("eq", {31'd0, bus.eq}, {31'd0, re.eq});
          check("done_id", {30'd0, bus.done_id}, {30'd0, re.id});
          check("mis_idx", {29'd0, bus.mis_idx}, {29'd0, re.mis});
          check("latency", cyc - job_gnt_cyc, W + 1);
        end
      end else begin
        check("idle_outs", {26'd0, bus.eq, bus.done_id, bus.mis_idx}, 32'd0);
      end
      if (bus.gnt != '0) in_job = 1'b1;
      else if (bus.done) in_job = 1'b0;
    end
  end

  task automatic set_ops(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.a_in[id*W +: W] = a;
    bus.b_in[id*W +: W] = b;
  endtask

  task automatic push_gnt(input logic [N-1:0] g, input int gap);
    gnt_exp_t e;
    e.gnt = g;
    e.gap = gap;
    gq.push_back(e);
  endtask

  task automatic push_res(input logic e_eq, input logic [1:0] id, input logic [2:0] mis);
    res_exp_t e;
    e.eq  = e_eq;
    e.id  = id;
    e.mis = mis;
    rq.push_back(e);
  endtask

  // One isolated request; a_late overwrites operand A right after the grant.
  task automatic single(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic e_eq, input logic [2:0] mis, input logic [W-1:0] a_late);
    set_ops(id, a, b);
    push_gnt(N'(1) << id, 0);
    push_res(e_eq, 2'(id), mis);
    bus.req = N'(1) << id;
    @(posedge clk); #1;
    bus.req = '0;
    bus.a_in[id*W +: W] = a_late;
    repeat (W + 1) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.req  = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    rst      = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Directed single requests, including first- and last-bit mismatches.
    single(0, 8'hA5, 8'hA5, 1'b1, 3'd0, 8'hA5);
    single(2, 8'hF0, 8'hB0, 1'b0, 3'd6, 8'hF0);
    single(3, 8'h00, 8'hFF, 1'b0, 3'd0, 8'h00);
    single(1, 8'h80, 8'h00, 1'b0, 3'd7, 8'h80);
    // Operand change after grant must not affect the result.
    single(1, 8'h3C, 8'h3C, 1'b1, 3'd0, 8'hFF);

    // Request raised while busy is granted right after DONE.
    set_ops(0, 8'h12, 8'h12);
    set_ops(3, 8'h55, 8'h54);
    push_gnt(4'b0001, 0);
    push_res(1'b1, 2'd0, 3'd0);
    push_gnt(4'b1000, W + 2);
    push_res(1'b0, 2'd3, 3'd0);
    bus.req = 4'b0001;
    @(posedge clk); #1;
    bus.req = '0;
    repeat (2) @(posedge clk); #1;
    bus.req = 4'b1000;
    repeat (8) @(posedge clk); #1;
    bus.req = '0;
    repeat (9) @(posedge clk); #1;

    // Reset in the middle of RUN aborts the job without a done pulse.
    set_ops(0, 8'h00, 8'h01);
    push_gnt(4'b0001, 0);
    bus.req = 4'b0001;
    @(posedge clk); #1;
    bus.req = '0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    set_ops(1, 8'h0F, 8'h0F);
    bus.req = 4'b0010;
    push_gnt(4'b0010, 0);
    push_res(1'b1, 2'd1, 3'd0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    bus.req = '0;
    repeat (9) @(posedge clk); #1;

    // Fairness: all four requesting from reset, grants rotate 0,1,2,3,0.
    rst = 1'b1;
    set_ops(0, 8'h11, 8'h11);
    set_ops(1, 8'h22, 8'h22);
    set_ops(2, 8'h33, 8'h3B);
    set_ops(3, 8'h44, 8'h44);
    bus.req = 4'b1111;
    push_gnt(4'b0001, 0);      push_res(1'b1, 2'd0, 3'd0);
    push_gnt(4'b0010, W + 2);  push_res(1'b1, 2'd1, 3'd0);
    push_gnt(4'b0100, W + 2);  push_res(1'b0, 2'd2, 3'd3);
    push_gnt(4'b1000, W + 2);  push_res(1'b1, 2'd3, 3'd0);
    push_gnt(4'b0001, W + 2);  push_res(1'b1, 2'd0, 3'd0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (4 * (W + 2) + 1) @(posedge clk); #1;
    bus.req = '0;
    repeat (W + 2) @(posedge clk); #1;

    // Drain with a bound; anything left over was never produced by the DUT.
    for (int i = 0; i < 40 && (gq.size() != 0 || rq.size() != 0); i++) @(posedge clk);
    check("grant_queue_empty", gq.size(), 0);
    check("result_queue_empty", rq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
